draw_arbiter: RTL and testbench
===============================

Name: draw_arbiter

Overview:
- Round-robin arbiter that shares the single VGA pixel-write port (x, y, colour, writeEn into the vga_adapter wrapper) between N drawing engines: ball, bricks, platform and loader.
- Replaces the fixed-delay draw sequencing with a req/gnt/done handshake, so an engine owns the port until it reports completion.
- Sits between the draw engines and the draw/vga_adapter instance.
- Includes a burst watchdog so a hung engine cannot lock the screen.

Parameters:
- N, 4, number of requesters (index 0 = highest priority after reset).
- IDX_W, 2, width of the owner index; must satisfy 2^IDX_W >= N.
- MAX_BURST, 1024, maximum cycles an owner may hold the port before forced release.
- SCREEN_W, 160, screen width in pixels (used only by the optional feature).
- SCREEN_H, 120, screen height in pixels (used only by the optional feature).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-engine request; level, held until done.
- done  in  N  per-engine one-cycle completion pulse.
- pix_x  in  N*10  packed x coordinates; requester i uses bits [10i+9:10i].
- pix_y  in  N*10  packed y coordinates, same packing as pix_x.
- pix_colour  in  N*3  packed colours.
- pix_we  in  N  per-engine pixel write strobe.
- gnt  out  N  one-hot grant, registered.
- owner  out  IDX_W  index of the current owner; valid while busy.
- busy  out  1  high from GRANT through RELEASE inclusive.
- x_out  out  10  to the VGA adapter.
- y_out  out  10  to the VGA adapter.
- colour_out  out  3  to the VGA adapter.
- writeEn  out  1  to the VGA adapter.
- timeout_err  out  1  one-cycle pulse on a watchdog release.

Behaviour:
- Reset values: gnt=0, owner=0, busy=0, x_out=0, y_out=0, colour_out=0, writeEn=0, timeout_err=0, state=IDLE, last_owner=N-1 (so requester 0 wins first), burst_cnt=0.
- Reset mid-burst aborts immediately. No pixel is forwarded in the reset cycle or the cycle after it.
- IDLE:
  - If any req bit is set, pick the first set bit scanning last_owner+1, last_owner+2, ... modulo N.
  - Register gnt (one-hot) and owner, set busy, go to GRANT.
  - If no req bit is set, stay in IDLE.
- GRANT:
  - One setup cycle; the owner sees gnt. writeEn=0, burst_cnt cleared.
  - Next state is BURST.
- BURST:
  - Each cycle, register the owner's pix_x/pix_y/pix_colour/pix_we onto the outputs. Latency is exactly 1 cycle from pix_we to writeEn.
  - pix_we from non-owners is ignored.
  - burst_cnt increments every cycle.
- BURST exit conditions, each going to RELEASE:
  - done[owner]=1, or req[owner]=0. The pixel presented in that same cycle is still forwarded.
  - burst_cnt == MAX_BURST-1: forced release with timeout_err pulsed for 1 cycle.
  - If done and timeout occur in the same cycle, done wins and timeout_err stays 0.
- RELEASE:
  - gnt=0, writeEn=0, last_owner<=owner, busy stays 1.
  - Next state is IDLE. The fastest back-to-back handover is therefore 3 cycles of dead time per arbitration.
- done pulses seen outside BURST, or on a non-owner index, are ignored.
- Round-robin fairness: with all N requesters held high continuously, grants rotate 0,1,2,3,0,...
- burst_cnt width is clog2(MAX_BURST)+1 bits. It saturates and never wraps.

Optional Feature:
- Macro: DRAW_ARB_CLIP_EN.
- Defined: a forwarded pixel with x >= SCREEN_W or y >= SCREEN_H has writeEn forced to 0. x_out, y_out and colour_out still update.
- Undefined: every owner pix_we is forwarded unconditionally; SCREEN_W and SCREEN_H are unused.

Decomposition:
- Shared package/header (alongside the existing macros file): state encodings DA_IDLE=0, DA_GRANT=1, DA_BURST=2, DA_RELEASE=3, plus the default screen dimensions 160/120.
- Sub-module rr_picker (combinational): inputs req and last_owner; outputs one-hot sel, index and any.
- All sequential logic stays in draw_arbiter.

Test Plan:
- Reset then req=4'b0001 → gnt=0001 two cycles later. In BURST, pix_we with x=5, y=7, colour=3'b100 → next cycle writeEn=1, x_out=5, y_out=7, colour_out=4. done pulse → RELEASE, then IDLE, busy=0.
- req=4'b1111 held, each owner pulsing done after 4 pixels → grant order 0,1,2,3,0. No writeEn from non-owners, and exactly 3 dead cycles between bursts.
- Owner 2 holds req and never asserts done, with MAX_BURST=16 → forced release after 16 BURST cycles, one timeout_err pulse, next grant goes to 3.
- done and timeout in the same cycle → release occurs with timeout_err=0.
- Owner 1 pixel at x=100 while owner 0 strobes pix_we at x=50 → only x_out=100 appears.
- reset asserted mid-burst → all outputs 0 on the next edge; after release, requester 0 is granted first. With DRAW_ARB_CLIP_EN: pixel (160,10) → writeEn=0; pixel (159,119) → writeEn=1.

Source files
------------

// File: rtl/draw_arbiter_pkg.sv
// draw_arbiter_pkg
//   Shared definitions for the VGA pixel-port arbiter: FSM state encoding,
//   pixel field widths, default screen dimensions and the on-screen test
//   used by the optional clipping feature (DRAW_ARB_CLIP_EN).
package draw_arbiter_pkg;

  typedef enum logic [1:0] {
    DA_IDLE    = 2'd0,
    DA_GRANT   = 2'd1,
    DA_BURST   = 2'd2,
    DA_RELEASE = 2'd3
  } da_state_t;

  localparam int DA_COORD_W  = 10;
  localparam int DA_COLOUR_W = 3;

  localparam int DA_SCREEN_W = 160;
  localparam int DA_SCREEN_H = 120;

  // True when (x, y) lies inside a w x h screen.
  function automatic logic da_on_screen(input logic [DA_COORD_W-1:0] x,
                                        input logic [DA_COORD_W-1:0] y,
                                        input int w,
                                        input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin selection. Scans requesters starting just
//   after last_owner and wrapping modulo N; the first set req bit wins.
//
// Ports:
//   req         in   N      request vector
//   last_owner  in   IDX_W  index of the most recent owner
//   sel         out  N      one-hot winner (all zero when no request)
//   index       out  IDX_W  winner index (0 when no request)
//   any         out  1      at least one request present
module rr_picker
  import draw_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N-1:0]     sel,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    sel   = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    // k runs 1..N so last_owner itself is checked last.
    for (int k = 1; k <= N; k++) begin
      cand = SEL_W'((int'(last_owner) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        sel[cand] = 1'b1;
        index     = IDX_W'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter
//   Round-robin owner of the single VGA pixel-write port shared by the
//   drawing engines (ball, bricks, platform, loader). An engine raises req,
//   receives a registered one-hot gnt, streams pixels and ends its burst
//   with a done pulse or by dropping req. A burst watchdog forcibly releases
//   an owner after MAX_BURST cycles and pulses timeout_err.
//
//   Optional build macro DRAW_ARB_CLIP_EN: forwarded pixels outside
//   SCREEN_W x SCREEN_H keep their coordinates on the outputs but have
//   writeEn held low.
//
// Ports:
//   clk          in   1       system clock
//   reset        in   1       synchronous active-high reset
//   req          in   N       per-engine request level
//   done         in   N       per-engine completion pulse
//   pix_x        in   N*10    packed x, requester i at [10i+9:10i]
//   pix_y        in   N*10    packed y
//   pix_colour   in   N*3     packed colour
//   pix_we       in   N       per-engine write strobe
//   gnt          out  N       one-hot grant
//   owner        out  IDX_W   current owner index (valid while busy)
//   busy         out  1       port owned (GRANT..RELEASE)
//   x_out        out  10      to VGA adapter
//   y_out        out  10      to VGA adapter
//   colour_out   out  3       to VGA adapter
//   writeEn      out  1       to VGA adapter
//   timeout_err  out  1       one-cycle pulse on watchdog release
//
// state      | meaning
// -----------+-----------------------------------------------------------
// DA_IDLE    | port free; pick next requester after last_owner
// DA_GRANT   | one setup cycle, owner sees gnt, burst counter cleared
// DA_BURST   | owner pixels forwarded with 1-cycle latency
// DA_RELEASE | gnt and writeEn dropped, last_owner updated
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int MAX_BURST = 1024,
  parameter int SCREEN_W  = DA_SCREEN_W,
  parameter int SCREEN_H  = DA_SCREEN_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             req,
  input  logic [N-1:0]             done,
  input  logic [N*DA_COORD_W-1:0]  pix_x,
  input  logic [N*DA_COORD_W-1:0]  pix_y,
  input  logic [N*DA_COLOUR_W-1:0] pix_colour,
  input  logic [N-1:0]             pix_we,
  output logic [N-1:0]             gnt,
  output logic [IDX_W-1:0]         owner,
  output logic                     busy,
  output logic [DA_COORD_W-1:0]    x_out,
  output logic [DA_COORD_W-1:0]    y_out,
  output logic [DA_COLOUR_W-1:0]   colour_out,
  output logic                     writeEn,
  output logic                     timeout_err
);

  localparam int              CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

`ifdef DRAW_ARB_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  da_state_t        state;
  logic [IDX_W-1:0] last_owner;
  logic [CNT_W-1:0] burst_cnt;

  logic [N-1:0]     pick_sel;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .sel        (pick_sel),
    .index      (pick_idx),
    .any        (pick_any)
  );

  // Unpack per-requester pixel fields so the owner mux is a plain array read.
  logic [DA_COORD_W-1:0]  x_arr      [N];
  logic [DA_COORD_W-1:0]  y_arr      [N];
  logic [DA_COLOUR_W-1:0] colour_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x_arr[i]      = pix_x[DA_COORD_W*i +: DA_COORD_W];
    assign y_arr[i]      = pix_y[DA_COORD_W*i +: DA_COORD_W];
    assign colour_arr[i] = pix_colour[DA_COLOUR_W*i +: DA_COLOUR_W];
  end

  logic [DA_COORD_W-1:0]  own_x;
  logic [DA_COORD_W-1:0]  own_y;
  logic [DA_COLOUR_W-1:0] own_colour;
  logic                   own_we;
  logic                   own_done;
  logic                   own_req;
  logic                   own_visible;
  logic                   fwd_we;
  logic                   burst_end;
  logic                   burst_timeout;

  assign own_x       = x_arr[owner];
  assign own_y       = y_arr[owner];
  assign own_colour  = colour_arr[owner];
  assign own_we      = pix_we[owner];
  assign own_done    = done[owner];
  assign own_req     = req[owner];
  assign own_visible = da_on_screen(own_x, own_y, SCREEN_W, SCREEN_H);

  // With clipping compiled out CLIP_EN is 0 and the screen test folds away.
  assign fwd_we = own_we & (~CLIP_EN | own_visible);

  // A normal end takes priority over the watchdog in the same cycle.
  assign burst_end     = own_done | ~own_req;
  assign burst_timeout = ~burst_end & (burst_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DA_IDLE;
      gnt         <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      colour_out  <= '0;
      writeEn     <= 1'b0;
      timeout_err <= 1'b0;
      last_owner  <= IDX_W'(N - 1);
      burst_cnt   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        DA_IDLE: begin
          writeEn <= 1'b0;
          if (pick_any) begin
            gnt   <= pick_sel;
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= DA_GRANT;
          end
        end

        DA_GRANT: begin
          writeEn   <= 1'b0;
          burst_cnt <= '0;
          state     <= DA_BURST;
        end

        DA_BURST: begin
          // The pixel in the exit cycle is still forwarded.
          x_out      <= own_x;
          y_out      <= own_y;
          colour_out <= own_colour;
          writeEn    <= fwd_we;
          if (burst_cnt != CNT_SAT) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (burst_end) begin
            state <= DA_RELEASE;
          end else if (burst_timeout) begin
            timeout_err <= 1'b1;
            state       <= DA_RELEASE;
          end
        end

        DA_RELEASE: begin
          gnt        <= '0;
          writeEn    <= 1'b0;
          busy       <= 1'b0;
          last_owner <= owner;
          state      <= DA_IDLE;
        end

        default: begin
          state <= DA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
module tb_draw_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int MB    = 16;

  localparam int M_DONE  = 0;
  localparam int M_DROP  = 1;
  localparam int M_HANG  = 2;
  localparam int M_RESET = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N-1:0]     done;
  logic [N*10-1:0]  pix_x;
  logic [N*10-1:0]  pix_y;
  logic [N*3-1:0]   pix_colour;
  logic [N-1:0]     pix_we;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic [9:0]       x_out;
  logic [9:0]       y_out;
  logic [2:0]       colour_out;
  logic             writeEn;
  logic             timeout_err;

  draw_arbiter #(
    .N         (N),
    .IDX_W     (IDX_W),
    .MAX_BURST (MB),
    .SCREEN_W  (160),
    .SCREEN_H  (120)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colour  (pix_colour),
    .pix_we      (pix_we),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour_out  (colour_out),
    .writeEn     (writeEn),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
    int         cyc;
  } pix_t;

  typedef struct {
    int idx;
    int cyc;
  } gnt_t;

  pix_t pix_q[$];
  gnt_t gnt_q[$];
  int   to_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [N-1:0] gnt_prev = '0;
  gnt_t         mg;
  pix_t         mp;
  int           mt;

  always @(negedge clk) begin
    if (gnt != '0 && gnt_prev == '0) begin
      if (gnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got gnt=%b expected none", gnt);
      end else begin
        mg = gnt_q.pop_front();
        check("grant_onehot", 32'(gnt), 32'(1) << mg.idx);
        check("grant_owner", 32'(owner), 32'(mg.idx));
        check("grant_cycle", 32'(cyc), 32'(mg.cyc));
        check("grant_busy", 32'(busy), 32'd1);
      end
    end
    gnt_prev = gnt;

    if (writeEn === 1'b1) begin
      if (pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d expected no write", x_out, y_out);
      end else begin
        mp = pix_q.pop_front();
        check("pixel_x", 32'(x_out), 32'(mp.x));
        check("pixel_y", 32'(y_out), 32'(mp.y));
        check("pixel_colour", 32'(colour_out), 32'(mp.c));
        check("pixel_cycle", 32'(cyc), 32'(mp.cyc));
      end
    end

    if (timeout_err === 1'b1) begin
      if (to_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_timeout: got timeout_err=1 expected 0");
      end else begin
        mt = to_q.pop_front();
        check("timeout_cycle", 32'(cyc), 32'(mt));
      end
    end
  end

  // ---------------- reference model + stimulus ----------------
  logic [N-1:0] pend;
  int           last_m;
  bit           from_rel;
  bit           abort = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit visible(input int x, input int y);
`ifdef DRAW_ARB_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive_junk();
    for (int i = 0; i < N; i++) begin
      pix_x[10*i +: 10]     = 10'($urandom_range(0, 1023));
      pix_y[10*i +: 10]     = 10'($urandom_range(0, 1023));
      pix_colour[3*i +: 3]  = 3'($urandom_range(0, 7));
    end
    pix_we = 4'($urandom_range(0, 15));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_x"}, 32'(x_out), 32'd0);
    check({tag, "_y"}, 32'(y_out), 32'd0);
    check({tag, "_colour"}, 32'(colour_out), 32'd0);
    check({tag, "_we"}, 32'(writeEn), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic arbitrate(input logic [N-1:0] add, output int o);
    gnt_t g;
    bit   seen;
    pend   = pend | add;
    req    = pend;
    o      = rr_pick(pend, last_m);
    g.idx  = o;
    g.cyc  = cyc + (from_rel ? 2 : 1);
    gnt_q.push_back(g);
    last_m = o;
    seen   = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      drive_junk();
      if (gnt != '0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      abort = 1'b1;
      $display("FAIL grant_wait: got no grant within 8 cycles expected owner %0d", o);
    end
  endtask

  task automatic burst(input int o, input int mode, input int len, input bit fixed);
    pix_t p;
    int   xv, yv, cv;
    bit   we;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      drive_junk();
      done = '0;
      if ($urandom_range(0, 3) == 0) done = 4'($urandom_range(0, 15)) & ~(4'd1 << o);
      if (fixed && c == 1) begin
        xv = 5; yv = 7; cv = 4; we = 1'b1;
        pix_x[10*((o+1)%N) +: 10] = 10'd50;
        pix_we[(o+1)%N] = 1'b1;
      end else begin
        xv = $urandom_range(0, 170);
        yv = $urandom_range(0, 125);
        cv = $urandom_range(0, 7);
        we = ($urandom_range(0, 3) != 0);
      end
      pix_x[10*o +: 10]    = 10'(xv);
      pix_y[10*o +: 10]    = 10'(yv);
      pix_colour[3*o +: 3] = 3'(cv);
      pix_we[o]            = we;
      if (mode == M_RESET && c == len) begin
        reset     = 1'b1;
        pix_we[o] = 1'b1;
      end else if (we && visible(xv, yv)) begin
        p.x = 10'(xv); p.y = 10'(yv); p.c = 3'(cv); p.cyc = cyc + 1;
        pix_q.push_back(p);
      end
      if (c == len) begin
        case (mode)
          M_DONE: done[o] = 1'b1;
          M_DROP: begin pend[o] = 1'b0; req[o] = 1'b0; end
          M_HANG: to_q.push_back(cyc + 1);
          default: ;
        endcase
      end
    end
  endtask

  task automatic round(input int mode, input int len, input logic [N-1:0] add_in, input bit fixed);
    int           o;
    logic [N-1:0] add;
    if (abort) return;
    add = add_in;
    if ((pend | add) == '0) begin
      if (from_rel) begin
        @(negedge clk);
        drive_junk();
        check("idle_busy", 32'(busy), 32'd0);
        from_rel = 1'b0;
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        drive_junk();
      end
      add = 4'd1 << $urandom_range(0, N-1);
    end
    arbitrate(add, o);
    if (abort) return;
    burst(o, mode, len, fixed);
    @(negedge clk);
    drive_junk();
    done = '0;
    if (mode == M_RESET) begin
      check_all_zero("midreset");
      reset    = 1'b0;
      pend     = 4'($urandom_range(0, 15)) | 4'd1;
      req      = pend;
      last_m   = N - 1;
      from_rel = 1'b0;
    end else begin
      check("release_busy", 32'(busy), 32'd1);
      if (mode == M_DONE) pend[o] = 1'b0;
      req      = pend;
      from_rel = 1'b1;
    end
  endtask

  task automatic random_round();
    int r;
    logic [N-1:0] add;
    r   = $urandom_range(0, 9);
    add = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    if (r <= 5)      round(M_DONE, $urandom_range(1, 10), add, 1'b0);
    else if (r == 6) round(M_DROP, $urandom_range(1, 10), add, 1'b0);
    else if (r == 7) round(M_HANG, MB, add, 1'b0);
    else if (r == 8) round(M_DONE, MB, add, 1'b0);
    else             round(M_DONE, MB - 1, add, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = '0; done = '0;
    drive_junk();
    pend = '0; last_m = N - 1; from_rel = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_req_busy", 32'(busy), 32'd0);

    round(M_DONE, 3, 4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) round(M_DONE, 4, 4'b1111, 1'b0);
    round(M_HANG, MB, 4'b0100, 1'b0);
    round(M_DONE, MB, 4'b0000, 1'b0);
    round(M_DROP, 5, 4'b0000, 1'b0);
    for (int i = 0; i < 40; i++) random_round();
    round(M_RESET, $urandom_range(2, 8), 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) random_round();

    req  = '0;
    pend = '0;
    done = '0;
    repeat (6) @(negedge clk);
    check("grant_queue_empty", 32'(gnt_q.size()), 32'd0);
    check("pixel_queue_empty", 32'(pix_q.size()), 32'd0);
    check("timeout_queue_empty", 32'(to_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
